sum_latch_uart_tx: RTL and testbench
====================================

# sum_latch_uart_tx

Parametrised successor to the two-button sum-latch UART path. It latches `NUM_OPS` operands of `DATA_W` bits from a shared input bus, one active-low save strobe per operand. Once every operand is held, it adds them and serialises the sum over UART, least significant byte first. It sits between the board's switch/button pins and the UART TX pin, and drives a busy flag plus the latched sum for on-chip status.

## Interface
- `DATA_W`, default 5: operand width.
- `NUM_OPS`, default 2: number of operands and save strobes (≥2).
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (≥2).
- Derived: `SUM_W = DATA_W + $clog2(NUM_OPS)`; `NUM_BYTES = ceil(SUM_W/8)`.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `data_input`  in  DATA_W  operand bus, sampled at the latch cycle (no synchroniser; must be quasi-static).
- `save_n`  in  NUM_OPS  active-low asynchronous save strobes, one per operand.
- `uart_txd`  out  1  UART serial out, idle high.
- `uart_tx_busy`  out  1  high from LOAD through the end of the last stop bit.
- `sum_out`  out  SUM_W  sum of the most recently launched round; holds.
- `sum_valid`  out  1  one-cycle pulse in the LOAD cycle.
- `op_valid`  out  NUM_OPS  per-operand "latched" flags for the current round.

## Operation
- Each `save_n[i]` goes through a 2-FF synchroniser and then a falling-edge detect.
  - On a detected fall, `data_input` is written into slot i and `op_valid[i]` is set.
  - Re-saving an already valid slot overwrites its value.
  - Simultaneous falls on several channels latch the same `data_input` into every affected slot.
- FSM states: IDLE, LOAD, START, DATA, PARITY (macro only), STOP, NEXT.
- IDLE → LOAD when all `op_valid` bits are set.
- LOAD:
  - Sum is computed zero-extended to SUM_W (no overflow is possible).
  - Sum is registered into `sum_out` and a shift register; `sum_valid` pulses.
  - `op_valid` is cleared and the byte index is reset to 0.
- START: `uart_txd`=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bits above SUM_W in the top byte are sent as 0.
- STOP: `uart_txd`=1 for CLKS_PER_BIT cycles.
- NEXT: if more bytes remain, increment the index and go to START; otherwise go to IDLE.
- Saves during transmission are accepted for the next round. The next round cannot launch before IDLE. A round that completes during TX launches on the first IDLE cycle.
- Reset mid-frame: `uart_txd` returns to 1 immediately; FSM, slots and flags are cleared. No partial frame resumes.
- Reset values: `uart_txd`=1, `uart_tx_busy`=0, `sum_out`=0, `sum_valid`=0, `op_valid`=0.

## Timing
- `save_n` low first sampled at edge k → `op_valid[i]` high after edge k+2.
- Final `op_valid` set at edge m → LOAD at edge m+1 (`sum_valid`, `uart_tx_busy` high). START begins at edge m+2.
- Frame length per byte: 10×CLKS_PER_BIT cycles, or 11× with parity.
- NEXT costs one cycle, during which `uart_txd` stays 1.
- `uart_tx_busy` falls on the cycle IDLE is re-entered.
- Bit counter wraps from CLKS_PER_BIT-1 to 0. The bit-index counter runs 0..7 only.

## Configuration
- `SUMLATCH_PARITY_EN`:
  - Defined: an even-parity bit (XOR of the 8 data bits) is sent in PARITY between DATA and STOP, giving 8E1.
  - Undefined: PARITY state and logic are absent, giving 8N1.

## Structure
- Package `sum_latch_pkg`: FSM state enum, frame-length constant helpers, and a `bytes_for(width)` function.
- One sub-module, `sum_latch_uart_byte_tx`.
  - Inputs: byte plus start. Outputs: txd and done.
  - Owns the baud counter, bit counter and parity.
- The top level owns the synchronisers, operand slots, adder, FSM sequencing and byte index.

## Test plan
- Reset released, no stimulus → `uart_txd`=1, busy=0, `op_valid`=0 for 100 cycles.
- DATA_W=5, NUM_OPS=2, CLKS_PER_BIT=4:
  - Save 31 on ch0, then 31 on ch1 → `sum_out`=62.
  - TX line shows 0, then 0,1,1,1,1,1,0,0, then 1; 40 cycles; busy drops after stop.
- DATA_W=8, NUM_OPS=4, all operands 255 → `sum_out`=1020. Two frames: 0xFC then 0x03, one idle-high NEXT cycle between them.
- During the first frame, save 3 and 4 → second round launches on the IDLE cycle after the stop bit, sending 7.
- Assert `reset` mid-DATA bit 3 → `uart_txd`=1 in the same cycle; after release, no frame until both operands are saved again.
- `SUMLATCH_PARITY_EN` defined, sum 0x07 → parity bit 1, frame 11×CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/sum_latch_uart_tx_pkg.sv
// Shared types and frame helpers for the sum-latch UART path.
// Optional macro SUMLATCH_PARITY_EN adds an even-parity bit (8E1 instead of 8N1).
package sum_latch_pkg;

  localparam int DATA_BITS = 8;

`ifdef SUMLATCH_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_NEXT
  } state_t;

  localparam int FRAME_BITS = 11;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_NEXT
  } state_t;

  localparam int FRAME_BITS = 10;
`endif

  function automatic int bytes_for(input int width);
    return (width + DATA_BITS - 1) / DATA_BITS;
  endfunction

  function automatic int frame_cycles(input int clks_per_bit);
    return FRAME_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/sum_latch_uart_tx_if.sv
// Operand bus, save strobes and UART/status outputs of the sum-latch UART path.
// The width of sum_out tracks DATA_W and NUM_OPS exactly as the core derives it.
interface sum_latch_uart_tx_if #(
  parameter int DATA_W  = 5,
  parameter int NUM_OPS = 2
);
  localparam int SUM_W = DATA_W + $clog2(NUM_OPS);

  logic [DATA_W-1:0]  data_input;
  logic [NUM_OPS-1:0] save_n;
  logic               uart_txd;
  logic               uart_tx_busy;
  logic [SUM_W-1:0]   sum_out;
  logic               sum_valid;
  logic [NUM_OPS-1:0] op_valid;

  modport master (
    output data_input,
    output save_n,
    input  uart_txd,
    input  uart_tx_busy,
    input  sum_out,
    input  sum_valid,
    input  op_valid
  );

  modport slave (
    input  data_input,
    input  save_n,
    output uart_txd,
    output uart_tx_busy,
    output sum_out,
    output sum_valid,
    output op_valid
  );

endinterface

// File: rtl/sum_latch_uart_byte_tx.sv
// Bit-timing datapath for one UART byte: baud counter, bit index, parity and line mux.
// Sequencing comes from the parent FSM via 'phase'; SUMLATCH_PARITY_EN enables the parity slot.
module sum_latch_uart_byte_tx
  import sum_latch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  state_t     phase,
  output logic       txd,
  output logic       bit_done,
  output logic       last_bit
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_reg;
  logic             in_frame;

  always_comb begin
    in_frame = (phase == ST_START) || (phase == ST_DATA) || (phase == ST_STOP);
`ifdef SUMLATCH_PARITY_EN
    if (phase == ST_PARITY) in_frame = 1'b1;
`endif
  end

  assign bit_done = in_frame && (baud_cnt == BAUD_MAX);
  assign last_bit = (bit_idx == 3'd7);

  // Baud counter idles at zero outside a frame so every bit starts a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      data_reg <= 8'd0;
    end else begin
      if (!in_frame || bit_done) baud_cnt <= '0;
      else                       baud_cnt <= baud_cnt + 1'b1;

      if (start) begin
        data_reg <= data;
        bit_idx  <= 3'd0;
      end else if ((phase == ST_DATA) && bit_done) begin
        bit_idx  <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    txd = 1'b1;
    case (phase)
      ST_START:  txd = 1'b0;
      ST_DATA:   txd = data_reg[bit_idx];
`ifdef SUMLATCH_PARITY_EN
      ST_PARITY: txd = ^data_reg;
`endif
      default:   txd = 1'b1;
    endcase
  end

endmodule

// File: rtl/sum_latch_uart_tx.sv
// Latches NUM_OPS operands on active-low save strobes, adds them and sends the sum LSB byte first.
// Define SUMLATCH_PARITY_EN for 8E1 framing; default is 8N1.
module sum_latch_uart_tx
  import sum_latch_pkg::*;
#(
  parameter int DATA_W       = 5,
  parameter int NUM_OPS      = 2,
  parameter int CLKS_PER_BIT = 434
) (
  input logic               clk,
  input logic               reset,
  sum_latch_uart_tx_if.slave bus
);

  localparam int SUM_W     = DATA_W + $clog2(NUM_OPS);
  localparam int NUM_BYTES = bytes_for(SUM_W);
  localparam int SHIFT_W   = NUM_BYTES * DATA_BITS;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  logic [NUM_OPS-1:0] sync1, sync2, prev, fall, op_valid;
  logic [DATA_W-1:0]  slots [NUM_OPS];
  logic [SUM_W-1:0]   sum, sum_reg;
  logic [SHIFT_W-1:0] shreg;
  logic [IDX_W-1:0]   byte_idx;
  logic               busy, sum_valid, launch, start;
  logic               txd, bit_done, last_bit;
  state_t             state;

  // Synchroniser flops idle high so releasing reset never looks like a falling strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= bus.save_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall   = prev & ~sync2;
  assign launch = (state == ST_IDLE) && (&op_valid);

  // A save landing on the launch edge belongs to the next round, so it beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_valid <= '0;
      for (int i = 0; i < NUM_OPS; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (fall[i]) begin
          slots[i]    <= bus.data_input;
          op_valid[i] <= 1'b1;
        end else if (launch) begin
          op_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_OPS; i++)
      sum = sum + {{(SUM_W - DATA_W){1'b0}}, slots[i]};
  end

  assign start = (state == ST_LOAD) || ((state == ST_NEXT) && (byte_idx != LAST_IDX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sum_reg   <= '0;
      shreg     <= '0;
      byte_idx  <= '0;
      busy      <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state     <= ST_LOAD;
            sum_reg   <= sum;
            shreg     <= SHIFT_W'(sum);
            byte_idx  <= '0;
            busy      <= 1'b1;
            sum_valid <= 1'b1;
          end
        end
        ST_LOAD:  state <= ST_START;
        ST_START: if (bit_done) state <= ST_DATA;
        ST_DATA: begin
          if (bit_done && last_bit) begin
`ifdef SUMLATCH_PARITY_EN
            state <= ST_PARITY;
`else
            state <= ST_STOP;
`endif
          end
        end
`ifdef SUMLATCH_PARITY_EN
        ST_PARITY: if (bit_done) state <= ST_STOP;
`endif
        ST_STOP: begin
          if (bit_done) begin
            state <= ST_NEXT;
            shreg <= shreg >> DATA_BITS;
          end
        end
        ST_NEXT: begin
          if (byte_idx == LAST_IDX) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            state    <= ST_START;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sum_latch_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data     (shreg[7:0]),
    .phase    (state),
    .txd      (txd),
    .bit_done (bit_done),
    .last_bit (last_bit)
  );

  assign bus.uart_txd     = txd;
  assign bus.uart_tx_busy = busy;
  assign bus.sum_out      = sum_reg;
  assign bus.sum_valid    = sum_valid;
  assign bus.op_valid     = op_valid;

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Directed bench for sum_latch_uart_tx: a 5-bit/2-operand and an 8-bit/4-operand instance at 4 clocks per bit.
// Honors SUMLATCH_PARITY_EN by inserting the expected even-parity bit into each frame.
module tb_sum_latch_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  sum_latch_uart_tx_if #(.DATA_W(5), .NUM_OPS(2)) bus_a ();
  sum_latch_uart_tx_if #(.DATA_W(8), .NUM_OPS(4)) bus_b ();

  sum_latch_uart_tx #(.DATA_W(5), .NUM_OPS(2), .CLKS_PER_BIT(CPB)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  sum_latch_uart_tx #(.DATA_W(8), .NUM_OPS(4), .CLKS_PER_BIT(CPB)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic cur_txd(input bit sel);
    return sel ? bus_b.uart_txd : bus_a.uart_txd;
  endfunction

  function automatic logic cur_busy(input bit sel);
    return sel ? bus_b.uart_tx_busy : bus_a.uart_tx_busy;
  endfunction

  function automatic logic cur_sum_valid(input bit sel);
    return sel ? bus_b.sum_valid : bus_a.sum_valid;
  endfunction

  function automatic logic [31:0] cur_sum(input bit sel);
    return sel ? 32'(bus_b.sum_out) : 32'(bus_a.sum_out);
  endfunction

  function automatic logic [31:0] cur_op_valid(input bit sel);
    return sel ? 32'(bus_b.op_valid) : 32'(bus_a.op_valid);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the strobes low long enough to pass the synchroniser, then releases them.
  task automatic applyStimulus(input bit sel, input logic [3:0] mask, input logic [7:0] val);
    if (sel) begin
      bus_b.data_input = val;
      bus_b.save_n     = ~mask;
    end else begin
      bus_a.data_input = val[4:0];
      bus_a.save_n     = ~mask[1:0];
    end
    repeat (3) @(negedge clk);
    if (sel) bus_b.save_n = 4'hF;
    else     bus_a.save_n = 2'b11;
  endtask

  task automatic wait_load(input bit sel);
    bit found = 1'b0;
    int n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (cur_sum_valid(sel) === 1'b1) found = 1'b1;
    end
    checkOutput("load_seen", 32'(found), 32'd1);
  endtask

  task automatic expect_frame(input bit sel, input logic [7:0] b);
    logic bits [12];
    int   n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = b[i]; n++;
    end
`ifdef SUMLATCH_PARITY_EN
    bits[n] = ^b; n++;
`endif
    bits[n] = 1'b1; n++;
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        checkOutput("txd_bit", 32'(cur_txd(sel)), 32'(bits[j]));
        if (j == 0 && c == 0) checkOutput("sum_valid_pulse", 32'(cur_sum_valid(sel)), 32'd0);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus_a.data_input = '0;
    bus_a.save_n     = 2'b11;
    bus_b.data_input = '0;
    bus_b.save_n     = 4'hF;
    idle(3);
    checkOutput("reset_txd", 32'(bus_a.uart_txd), 32'd1);
    checkOutput("reset_busy", 32'(bus_a.uart_tx_busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("quiet_txd", 32'(bus_a.uart_txd), 32'd1);
      checkOutput("quiet_busy", 32'(bus_a.uart_tx_busy), 32'd0);
      checkOutput("quiet_op_valid", 32'(bus_a.op_valid), 32'd0);
    end
    checkOutput("quiet_b_txd", 32'(bus_b.uart_txd), 32'd1);
    checkOutput("quiet_b_busy", 32'(bus_b.uart_tx_busy), 32'd0);
    checkOutput("quiet_b_op_valid", 32'(bus_b.op_valid), 32'd0);
    checkOutput("quiet_b_sum", cur_sum(1), 32'd0);
    checkOutput("quiet_b_sum_valid", 32'(bus_b.sum_valid), 32'd0);

    // 31 + 31 = 62, with a 3 + 4 round queued up while 62 is on the line.
    applyStimulus(0, 4'b0001, 8'd31);
    checkOutput("a_op_valid_0", cur_op_valid(0), 32'b01);
    idle(3);
    applyStimulus(0, 4'b0010, 8'd31);
    checkOutput("a_op_valid_1", cur_op_valid(0), 32'b11);
    wait_load(0);
    checkOutput("a_sum_62", cur_sum(0), 32'd62);
    checkOutput("a_load_busy", 32'(cur_busy(0)), 32'd1);
    checkOutput("a_load_txd", 32'(cur_txd(0)), 32'd1);
    checkOutput("a_load_op_clear", cur_op_valid(0), 32'd0);
    fork
      expect_frame(0, 8'h3E);
      begin
        idle(6);
        applyStimulus(0, 4'b0001, 8'd3);
        idle(3);
        applyStimulus(0, 4'b0010, 8'd4);
      end
    join
    @(negedge clk);
    checkOutput("a_next_txd", 32'(cur_txd(0)), 32'd1);
    checkOutput("a_next_busy", 32'(cur_busy(0)), 32'd1);
    checkOutput("a_held_round", cur_op_valid(0), 32'b11);
    @(negedge clk);
    checkOutput("a_idle_busy", 32'(cur_busy(0)), 32'd0);
    checkOutput("a_idle_sum_hold", cur_sum(0), 32'd62);
    @(negedge clk);
    checkOutput("a_relaunch_valid", 32'(cur_sum_valid(0)), 32'd1);
    checkOutput("a_sum_7", cur_sum(0), 32'd7);
    checkOutput("a_relaunch_busy", 32'(cur_busy(0)), 32'd1);
    expect_frame(0, 8'h07);
    @(negedge clk);
    checkOutput("a7_next_busy", 32'(cur_busy(0)), 32'd1);
    @(negedge clk);
    checkOutput("a7_idle_busy", 32'(cur_busy(0)), 32'd0);

    // Four operands of 255 give 1020 = 0x3FC, sent as 0xFC then 0x03.
    applyStimulus(1, 4'b0001, 8'd255);
    checkOutput("b_op_valid_0", cur_op_valid(1), 32'b0001);
    idle(3);
    applyStimulus(1, 4'b0010, 8'd255);
    checkOutput("b_op_valid_1", cur_op_valid(1), 32'b0011);
    idle(3);
    applyStimulus(1, 4'b1100, 8'd255);
    checkOutput("b_op_valid_all", cur_op_valid(1), 32'b1111);
    wait_load(1);
    checkOutput("b_sum_1020", cur_sum(1), 32'd1020);
    checkOutput("b_load_busy", 32'(cur_busy(1)), 32'd1);
    expect_frame(1, 8'hFC);
    @(negedge clk);
    checkOutput("b_next_txd", 32'(cur_txd(1)), 32'd1);
    checkOutput("b_next_busy", 32'(cur_busy(1)), 32'd1);
    expect_frame(1, 8'h03);
    @(negedge clk);
    checkOutput("b_last_next_busy", 32'(cur_busy(1)), 32'd1);
    @(negedge clk);
    checkOutput("b_idle_busy", 32'(cur_busy(1)), 32'd0);
    checkOutput("b_idle_txd", 32'(cur_txd(1)), 32'd1);

    // Sum 3 puts a 0 on data bit 3; reset there must snap the line high at once.
    applyStimulus(0, 4'b0001, 8'd1);
    idle(3);
    applyStimulus(0, 4'b0010, 8'd2);
    wait_load(0);
    checkOutput("a_sum_3", cur_sum(0), 32'd3);
    idle(18);
    checkOutput("a_bit3_low", 32'(cur_txd(0)), 32'd0);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_txd", 32'(cur_txd(0)), 32'd1);
    checkOutput("rst_busy", 32'(cur_busy(0)), 32'd0);
    checkOutput("rst_sum", cur_sum(0), 32'd0);
    checkOutput("rst_op_valid", cur_op_valid(0), 32'd0);
    checkOutput("rst_sum_valid", 32'(cur_sum_valid(0)), 32'd0);
    idle(2);
    reset = 1'b0;
    applyStimulus(0, 4'b0001, 8'd9);
    checkOutput("post_rst_op_valid", cur_op_valid(0), 32'b01);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput("post_rst_txd", 32'(cur_txd(0)), 32'd1);
      checkOutput("post_rst_busy", 32'(cur_busy(0)), 32'd0);
    end
    applyStimulus(0, 4'b0010, 8'd6);
    wait_load(0);
    checkOutput("a_sum_15", cur_sum(0), 32'd15);
    expect_frame(0, 8'h0F);
    @(negedge clk);
    @(negedge clk);
    checkOutput("a15_idle_busy", 32'(cur_busy(0)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
